// File: rtl/jtpang_objdma_if.sv
// Bus bundle between jtpang_objdma (master side) and the main CPU / RAM / object
// buffer environment (slave side).
interface jtpang_objdma_if #(
  parameter int AW = 12,
  parameter int OW = 9
) ();
  logic          dma_go;
  logic          busak_n;
  logic          busrq;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_dout;
  logic [OW-1:0] obj_addr;
  logic [7:0]    obj_din;
  logic          obj_we;
  logic          busy;

  modport master (
    input  dma_go, busak_n, src_dout,
    output busrq, src_addr, obj_addr, obj_din, obj_we, busy
  );

  modport slave (
    output dma_go, busak_n, src_dout,
    input  busrq, src_addr, obj_addr, obj_din, obj_we, busy
  );
endinterface

// File: rtl/jtpang_objdma.sv
// Object DMA: takes the Z80 bus and copies LEN bytes of object RAM into the
// object line buffer. Optional macro JTPANG_OBJDMA_VB_EN gates starts to vblank.
module jtpang_objdma #(
  parameter int AW  = 12,
  parameter int LEN = 512,
  parameter int OW  = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic LVBL,
  jtpang_objdma_if.master bus
);

  localparam int CW = OW + 1;
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          pending_r, pending_s;
  logic          go_d_r;
  logic          busrq_r, busrq_s;
  logic          busy_r, busy_s;
  logic [AW-1:0] src_addr_r, src_addr_s;
  logic [OW-1:0] obj_addr_r, obj_addr_s;
  logic [7:0]    obj_din_r, obj_din_s;
  logic          obj_we_r, obj_we_s;
  logic [7:0]    hold_r, hold_s;
  logic          hold_vld_r, hold_vld_s;
  logic          go_rise_s;
  logic          start_ok_s;

  assign go_rise_s = bus.dma_go & ~go_d_r;

`ifdef JTPANG_OBJDMA_VB_EN
  assign start_ok_s = ~LVBL;
`else
  logic unused_lvbl_s;
  assign unused_lvbl_s = LVBL;
  assign start_ok_s    = 1'b1;
`endif

  // Next-state and datapath decode; everything advances only on cen.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    pending_s  = pending_r;
    busrq_s    = busrq_r;
    busy_s     = busy_r;
    src_addr_s = src_addr_r;
    obj_addr_s = obj_addr_r;
    obj_din_s  = obj_din_r;
    obj_we_s   = 1'b0;
    hold_s     = hold_r;
    hold_vld_s = hold_vld_r;
    if (cen) begin
      case (state_r)
        IDLE: begin
          if (pending_r && start_ok_s) begin
            pending_s = 1'b0;
            cnt_s     = ZERO_C;
            busy_s    = 1'b1;
            busrq_s   = 1'b1;
            state_s   = REQ;
          end else begin
            state_s = IDLE;
          end
        end
        REQ: begin
          if (!bus.busak_n) begin
            src_addr_s = '0;
            hold_vld_s = 1'b0;
            state_s    = XFER;
          end else begin
            state_s = REQ;
          end
        end
        XFER: begin
          if (!bus.busak_n) begin
            src_addr_s = AW'(cnt_r + ONE_C);
            hold_vld_s = 1'b0;
            cnt_s      = cnt_r + ONE_C;
            if (cnt_r != ZERO_C) begin
              obj_we_s   = 1'b1;
              obj_addr_s = OW'(cnt_r - ONE_C);
              obj_din_s  = hold_vld_r ? hold_r : bus.src_dout;
            end else begin
              obj_we_s = 1'b0;
            end
            if (cnt_r == LEN_C) begin
              state_s = DONE;
            end else begin
              state_s = XFER;
            end
          end else begin
            // RAM keeps reading the held address while stalled, so the byte
            // fetched just before the stall is parked here until the bus returns.
            if (!hold_vld_r) begin
              hold_s     = bus.src_dout;
              hold_vld_s = 1'b1;
            end else begin
              hold_s = hold_r;
            end
          end
        end
        DONE: begin
          busrq_s = 1'b0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end
        default: begin
          busrq_s = 1'b0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    pending_s = go_rise_s ? 1'b1 : pending_s;
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO_C;
      pending_r  <= 1'b0;
      go_d_r     <= 1'b0;
      busrq_r    <= 1'b0;
      busy_r     <= 1'b0;
      src_addr_r <= '0;
      obj_addr_r <= '0;
      obj_din_r  <= 8'd0;
      obj_we_r   <= 1'b0;
      hold_r     <= 8'd0;
      hold_vld_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pending_r  <= pending_s;
      go_d_r     <= bus.dma_go;
      busrq_r    <= busrq_s;
      busy_r     <= busy_s;
      src_addr_r <= src_addr_s;
      obj_addr_r <= obj_addr_s;
      obj_din_r  <= obj_din_s;
      obj_we_r   <= obj_we_s;
      hold_r     <= hold_s;
      hold_vld_r <= hold_vld_s;
    end
  end

  assign bus.busrq    = busrq_r;
  assign bus.busy     = busy_r;
  assign bus.src_addr = src_addr_r;
  assign bus.obj_addr = obj_addr_r;
  assign bus.obj_din  = obj_din_r;
  assign bus.obj_we   = obj_we_r;

endmodule
